// File: rtl/irq_ctrl.sv
// PDP-8 program-interrupt controller: ION/IOF enable FSM, request collection, forced-JMS override.
// Optional device mask register enabled by defining IRQ_MASK_EN.
module irq_ctrl #(
  parameter int NIRQ = 8
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic            ckFetch,
  input  logic            instDone,
  input  logic [NIRQ-1:0] irqLines,
  input  logic            iopION,
  input  logic            iopIOF,
  input  logic            iopSKON,
  input  logic            iopSRQ,
  input  logic            iopCAF,
  input  logic            iopMSK,
  input  logic [11:0]     busAC,
  output logic            irqOverride,
  output logic            irqTaken,
  output logic            skip,
  output logic            ionFlag,
  output logic            intPending,
  output logic [1:0]      dbgState
);

  typedef enum logic [1:0] {
    stOff  = 2'd0,
    stArm  = 2'd1,
    stWait = 2'd2,
    stOn   = 2'd3
  } ionState_t;

  ionState_t       state, stateNext;
  logic            lastCkFetch;
  logic            fetchEdge;
  logic            take;
  logic            anyReq;
  logic [NIRQ-1:0] mask;
  logic            unusedBits;

`ifdef IRQ_MASK_EN
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      mask <= '1;
    end else if (iopCAF) begin
      mask <= '1;
    end else if (iopMSK) begin
      mask <= busAC[NIRQ-1:0];
    end
  end
`else
  assign mask = '1;
`endif

  assign unusedBits = ^{busAC, iopMSK};

  assign anyReq    = |(irqLines & mask);
  assign fetchEdge = ckFetch & ~lastCkFetch;
  assign take      = fetchEdge & irqOverride;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= stOff;
    end else begin
      state <= stateNext;
    end
  end

  // ION needs two instDone pulses: its own completion, then one more instruction.
  always_comb begin
    stateNext = state;
    if (iopION && state != stOn) begin
      stateNext = instDone ? stWait : stArm;
    end else if (state == stArm && instDone) begin
      stateNext = stWait;
    end else if (state == stWait && instDone) begin
      stateNext = stOn;
    end
    if (iopIOF || iopCAF || iopSKON || take) begin
      stateNext = stOff;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      lastCkFetch <= 1'b0;
      irqOverride <= 1'b0;
      irqTaken    <= 1'b0;
      skip        <= 1'b0;
      intPending  <= 1'b0;
    end else begin
      lastCkFetch <= ckFetch;
      // Frozen while ckFetch is high so the instruction register sees a stable value.
      if (!ckFetch) begin
        irqOverride <= (state == stOn) & anyReq;
      end
      irqTaken   <= take;
      skip       <= (iopSKON & (state == stOn)) | (iopSRQ & intPending);
      intPending <= anyReq;
    end
  end

  assign ionFlag  = (state == stOn);
  assign dbgState = state;

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed vectors with literal checks plus a per-cycle behavioural model.
module tb_irq_ctrl;
  localparam int NIRQ = 8;

  logic            CLK = 1'b0;
  logic            RESET_N = 1'b0;
  logic            ckFetch = 1'b0;
  logic            instDone = 1'b0;
  logic [NIRQ-1:0] irqLines = '0;
  logic            iopION = 1'b0, iopIOF = 1'b0, iopSKON = 1'b0;
  logic            iopSRQ = 1'b0, iopCAF = 1'b0, iopMSK = 1'b0;
  logic [11:0]     busAC = '0;
  logic            irqOverride, irqTaken, skip, ionFlag, intPending;
  logic [1:0]      dbgState;

  int nChecks = 0;
  int nFails  = 0;
  bit chkOn   = 1'b0;

  irq_ctrl #(.NIRQ(NIRQ)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .ckFetch(ckFetch), .instDone(instDone),
    .irqLines(irqLines), .iopION(iopION), .iopIOF(iopIOF), .iopSKON(iopSKON),
    .iopSRQ(iopSRQ), .iopCAF(iopCAF), .iopMSK(iopMSK), .busAC(busAC),
    .irqOverride(irqOverride), .irqTaken(irqTaken), .skip(skip),
    .ionFlag(ionFlag), .intPending(intPending), .dbgState(dbgState)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic act, input logic exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  // behavioural model: enable is a countdown of instDone pulses still owed after ION
  bit              mEn = 0;
  int              mNeed = 0;
  logic [NIRQ-1:0] mMask = '1;
  bit              mPend = 0, mOvr = 0, mLastF = 0, mTaken = 0, mSkip = 0;

  always @(posedge CLK or negedge RESET_N) begin
    bit req, took;
    if (!RESET_N) begin
      mEn = 0; mNeed = 0; mMask = '1; mPend = 0;
      mOvr = 0; mLastF = 0; mTaken = 0; mSkip = 0;
    end else begin
      req   = |(irqLines & mMask);
      took  = ckFetch && !mLastF && mOvr;
      mSkip = (iopSKON && mEn) || (iopSRQ && mPend);
      mTaken = took;
      if (!ckFetch) mOvr = mEn && req;
      mPend  = req;
      mLastF = ckFetch;
      if (iopION && !mEn) begin
        mNeed = instDone ? 1 : 2;
      end else if (mNeed > 0 && instDone) begin
        mNeed = mNeed - 1;
        if (mNeed == 0) mEn = 1;
      end
      if (iopIOF || iopCAF || iopSKON || took) begin
        mEn = 0;
        mNeed = 0;
      end
`ifdef IRQ_MASK_EN
      if (iopCAF) mMask = '1;
      else if (iopMSK) mMask = busAC[NIRQ-1:0];
`endif
    end
  end

  // scoreboard compare on the inactive edge
  always @(negedge CLK) begin
    if (chkOn) begin
      chk("m_irqOverride", irqOverride, mOvr);
      chk("m_irqTaken", irqTaken, mTaken);
      chk("m_skip", skip, mSkip);
      chk("m_ionFlag", ionFlag, mEn);
      chk("m_intPending", intPending, mPend);
    end
  end

  // driver tasks
  task automatic tick(input int n = 1);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic fetchPulse();
    ckFetch = 1'b1; tick(); ckFetch = 1'b0; tick();
  endtask

  task automatic donePulse();
    instDone = 1'b1; tick(); instDone = 1'b0; tick();
  endtask

  task automatic ionSeq();
    iopION = 1'b1; tick(); iopION = 1'b0; tick();
    donePulse();
    instDone = 1'b1; tick(); instDone = 1'b0;
  endtask

  initial begin
    chkOn = 1'b1;
    tick(3);
    chk("rst_irqOverride", irqOverride, 1'b0);
    chk("rst_irqTaken", irqTaken, 1'b0);
    chk("rst_skip", skip, 1'b0);
    chk("rst_ionFlag", ionFlag, 1'b0);
    chk("rst_intPending", intPending, 1'b0);
    RESET_N = 1'b1; tick();

    // request while interrupts are off
    irqLines = 8'h01; tick();
    chk("off_intPending", intPending, 1'b1);
    chk("off_ovr0", irqOverride, 1'b0);
    fetchPulse();
    chk("off_ovr1", irqOverride, 1'b0);
    chk("off_ion", ionFlag, 1'b0);

    // ION delay, then a take
    irqLines = '0;
    iopION = 1'b1; instDone = 1'b1; tick(); iopION = 1'b0; instDone = 1'b0;
    irqLines = 8'h08;
    fetchPulse();
    chk("wait_ovr", irqOverride, 1'b0);
    instDone = 1'b1; tick(); instDone = 1'b0;
    chk("ion_on", ionFlag, 1'b1);
    tick();
    chk("on_ovr", irqOverride, 1'b1);
    ckFetch = 1'b1; tick();
    chk("take_pulse", irqTaken, 1'b1);
    chk("take_ionoff", ionFlag, 1'b0);
    chk("take_ovr_hold", irqOverride, 1'b1);
    ckFetch = 1'b0; tick();
    chk("take_end", irqTaken, 1'b0);
    chk("ovr_fall", irqOverride, 1'b0);

    // SKON, ION while ON
    irqLines = '0; tick();
    ionSeq();
    chk("skon_ion", ionFlag, 1'b1);
    iopION = 1'b1; tick(); iopION = 1'b0;
    chk("ion_stay_on", ionFlag, 1'b1);
    iopSKON = 1'b1; tick(); iopSKON = 1'b0;
    chk("skon_skip", skip, 1'b1);
    chk("skon_off", ionFlag, 1'b0);
    tick();
    chk("skon_oneshot", skip, 1'b0);
    iopSKON = 1'b1; tick(); iopSKON = 1'b0;
    chk("skon_again", skip, 1'b0);

    // SRQ
    iopSRQ = 1'b1; tick(); iopSRQ = 1'b0;
    chk("srq_none", skip, 1'b0);
    irqLines = 8'h20; tick();
    iopSRQ = 1'b1; tick(); iopSRQ = 1'b0;
    chk("srq_req", skip, 1'b1);
    tick();
    chk("srq_oneshot", skip, 1'b0);

    // ION and IOF together; reset during WAIT
    irqLines = '0;
    iopION = 1'b1; iopIOF = 1'b1; tick(); iopION = 1'b0; iopIOF = 1'b0;
    donePulse(); donePulse();
    chk("ion_iof", ionFlag, 1'b0);
    iopION = 1'b1; tick(); iopION = 1'b0;
    donePulse();
    RESET_N = 1'b0; tick();
    chk("rst_wait_ion", ionFlag, 1'b0);
    RESET_N = 1'b1; tick();
    donePulse(); donePulse();
    chk("rst_wait_after", ionFlag, 1'b0);

    // IOF coincident with a taking fetch edge
    irqLines = 8'h01;
    ionSeq();
    tick();
    chk("iof_ovr", irqOverride, 1'b1);
    ckFetch = 1'b1; iopIOF = 1'b1; tick(); iopIOF = 1'b0;
    chk("iof_take", irqTaken, 1'b1);
    chk("iof_off", ionFlag, 1'b0);
    ckFetch = 1'b0; irqLines = '0; tick(2);

`ifdef IRQ_MASK_EN
    busAC = 12'o376; iopMSK = 1'b1; tick(); iopMSK = 1'b0;
    ionSeq();
    irqLines = 8'h01; tick(2);
    chk("msk_ovr0", irqOverride, 1'b0);
    chk("msk_pend0", intPending, 1'b0);
    irqLines = 8'h02; tick();
    chk("msk_ovr1", irqOverride, 1'b1);
    chk("msk_pend1", intPending, 1'b1);
    iopCAF = 1'b1; tick(); iopCAF = 1'b0;
    chk("caf_off", ionFlag, 1'b0);
    irqLines = 8'h01; tick();
    chk("caf_mask", intPending, 1'b1);
    irqLines = '0; tick();
`endif

    // mixed directed-random traffic checked by the model only
    for (int i = 0; i < 400; i++) begin
      ckFetch  = ($urandom_range(0, 2) == 0);
      instDone = ($urandom_range(0, 3) == 0);
      irqLines = ($urandom_range(0, 3) == 0) ? NIRQ'($urandom_range(0, 255)) : '0;
      iopION   = ($urandom_range(0, 7) == 0);
      iopIOF   = ($urandom_range(0, 40) == 0);
      iopSKON  = ($urandom_range(0, 30) == 0);
      iopSRQ   = ($urandom_range(0, 10) == 0);
      iopCAF   = ($urandom_range(0, 60) == 0);
      iopMSK   = ($urandom_range(0, 20) == 0);
      busAC    = 12'($urandom_range(0, 4095));
      tick();
    end
    {ckFetch, instDone, iopION, iopIOF, iopSKON, iopSRQ, iopCAF, iopMSK} = '0;
    irqLines = '0;
    tick(2);

    chkOn = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
